led_sequencer: RTL and testbench

Avalon-MM slave that sequences the 8-bit board LED bank. It sits on the HPS lightweight bridge in place of a static LED register. Software programs a seed pattern, a step period and a motion mode; the block then shifts or rotates the pattern autonomously. The push-buttons give local pause/resume and single-step control, arbitrated against bus writes.

---
 rtl/led_sequencer.sv | 93 +++++++++
 tb/tb_led_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: Avalon-MM LED pattern sequencer with push-button pause and single-step
module led_sequencer #(
  parameter logic [23:0] DEFAULT_PERIOD  = 24'd12499999,
  parameter logic [7:0]  DEFAULT_PATTERN = 8'h01,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s0_address,
  input  logic        s0_read,
  output logic [31:0] s0_readdata,
  input  logic        s0_write,
  input  logic [31:0] s0_writedata,
  input  logic [3:0]  button_n,
  output logic [7:0]  leds
);
  localparam logic [0:0] STOP = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] state;
  logic [1:0] mode;
  logic btn_en, dir;
  logic [23:0] period, count;
  logic [7:0] pattern, rot;
  logic [1:0][SYNC_STAGES-1:0] sync;
  logic [1:0] prev, press;
  logic run, ctrl_wr, pat_wr, tick, step, adv, go_right, unused_ok;
  // Decode strobes, button pulses, tick and the candidate next pattern
  always_comb begin
    run = state == RUN;
    ctrl_wr = s0_write & ~s0_address;
    pat_wr = s0_write & s0_address;
    press = prev & ~{sync[1][SYNC_STAGES-1], sync[0][SYNC_STAGES-1]};
    tick = run && count == period;
    step = press[1] & btn_en & ~run;
    adv = (tick | step) & ~pat_wr;
    go_right = mode == 2'd2 || (mode == 2'd3 && dir);
    rot = mode == 2'd0 ? pattern : go_right ? {pattern[0], pattern[7:1]} : {pattern[6:0], pattern[7]};
    unused_ok = ^button_n[3:2];
  end
  // Button synchronizers and falling-edge history; released buttons read as 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      prev <= '1;
    end else begin
      sync[0] <= {sync[0][SYNC_STAGES-2:0], button_n[0]};
      sync[1] <= {sync[1][SYNC_STAGES-2:0], button_n[1]};
      prev <= {sync[1][SYNC_STAGES-1], sync[0][SYNC_STAGES-1]};
    end
  end
  // Run/stop FSM and control bits; a CTRL write overrides a same-cycle pause press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STOP;
      mode <= 2'd0;
      btn_en <= 1'b0;
    end else if (ctrl_wr) begin
      state <= s0_writedata[0] ? RUN : STOP;
      mode <= s0_writedata[2:1];
      btn_en <= s0_writedata[3];
    end else if (press[0] && btn_en) begin
      state <= run ? STOP : RUN;
    end
  end
  // Prescaler, pattern and bounce direction; a pattern write suppresses any advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= DEFAULT_PERIOD;
      pattern <= DEFAULT_PATTERN;
      count <= '0;
      dir <= 1'b0;
    end else if (pat_wr) begin
      period <= s0_writedata[31:8];
      pattern <= s0_writedata[7:0];
      count <= '0;
      dir <= 1'b0;
    end else begin
      count <= (!run || tick) ? '0 : count + 24'd1;
      if (adv) pattern <= rot;
      if (adv && mode == 2'd3) dir <= dir ? ~rot[0] : rot[7];
    end
  end
  // LED drive follows the pattern register one clock later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) leds <= DEFAULT_PATTERN;
    else leds <= pattern;
  end
  // Registered read port with latency 1; holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s0_readdata <= '0;
    else if (s0_read) s0_readdata <= s0_address ? {period, pattern} : {leds, 15'b0, dir, run, 3'b0, btn_en, mode, run};
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized bench against a cycle reference model of the LED sequencer
module tb_led_sequencer;
  localparam logic [23:0] DP = 24'd40;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s0_address = 1'b0;
  logic s0_read = 1'b0;
  logic s0_write = 1'b0;
  logic [31:0] s0_writedata = '0;
  logic [31:0] s0_readdata;
  logic [3:0] button_n = 4'hF;
  logic [7:0] leds;
  int n_vec = 0;
  int n_err = 0;
  bit m_run, m_en, m_dir;
  logic [1:0] m_mode;
  logic [23:0] m_period, m_count;
  logic [7:0] m_pat, m_leds;
  logic [31:0] m_rd;
  bit q0[$];
  bit q1[$];

  led_sequencer #(.DEFAULT_PERIOD(DP), .DEFAULT_PATTERN(8'h01), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .s0_address(s0_address), .s0_read(s0_read),
    .s0_readdata(s0_readdata), .s0_write(s0_write), .s0_writedata(s0_writedata),
    .button_n(button_n), .leds(leds)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] p);
    return 8'((p << 1) | (p >> 7));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] p);
    return 8'((p >> 1) | (p << 7));
  endfunction

  task automatic model_reset();
    m_run = 0; m_en = 0; m_dir = 0; m_mode = 2'd0;
    m_period = DP; m_count = 0; m_pat = 8'h01; m_leds = 8'h01; m_rd = 0;
    q0.delete(); q1.delete();
    for (int i = 0; i <= S; i++) begin
      q0.push_back(1'b1);
      q1.push_back(1'b1);
    end
  endtask

  // One clock edge of the reference: a press is a 1->0 step seen S+1 edges late
  task automatic model_step();
    bit p0, p1, tick, adv, pw, cw, nd;
    logic [7:0] np;
    logic [23:0] nc;
    p0 = q0[S] && !q0[S-1];
    p1 = q1[S] && !q1[S-1];
    void'(q0.pop_back()); q0.push_front(button_n[0]);
    void'(q1.pop_back()); q1.push_front(button_n[1]);
    pw = s0_write && s0_address;
    cw = s0_write && !s0_address;
    tick = m_run && m_count == m_period;
    adv = (tick || (p1 && m_en && !m_run)) && !pw;
    nc = (!m_run || tick) ? 24'd0 : m_count + 24'd1;
    np = m_pat;
    nd = m_dir;
    if (adv) begin
      if (m_mode == 2'd1) np = rotl(m_pat);
      else if (m_mode == 2'd2) np = rotr(m_pat);
      else if (m_mode == 2'd3) begin
        np = m_dir ? rotr(m_pat) : rotl(m_pat);
        if (!m_dir && np[7]) nd = 1;
        else if (m_dir && np[0]) nd = 0;
      end
    end
    if (s0_read) m_rd = s0_address ? {m_period, m_pat} : {m_leds, 15'b0, m_dir, m_run, 3'b0, m_en, m_mode, m_run};
    m_leds = m_pat;
    if (pw) begin
      m_period = s0_writedata[31:8]; m_pat = s0_writedata[7:0]; m_count = 0; m_dir = 0;
    end else begin
      m_pat = np; m_dir = nd; m_count = nc;
    end
    if (cw) begin
      m_run = s0_writedata[0]; m_mode = s0_writedata[2:1]; m_en = s0_writedata[3];
    end else if (p0 && m_en) m_run = !m_run;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("leds", 32'(leds), 32'(m_leds));
    check("readdata", s0_readdata, m_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    s0_write = 1; s0_address = a; s0_writedata = d;
    cycle();
    s0_write = 0;
  endtask

  task automatic rd(input logic a);
    s0_read = 1; s0_address = a;
    cycle();
    s0_read = 0;
  endtask

  task automatic press(input int b);
    button_n[b] = 1'b0;
    cycle();
    button_n[b] = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_leds", 32'(leds), 32'h01);
    check("reset_rdata", s0_readdata, 32'h0);
    reset_n = 1'b1;
    rd(0);
    check("rd_ctrl_reset", s0_readdata, 32'h0100_0000);
    rd(1);
    check("rd_pat_reset", s0_readdata, {DP, 8'h01});
    idle(100);
    check("static_after_100", 32'(leds), 32'h01);
    wr(1, 32'h0000_0381);
    wr(0, 32'h3);
    idle(20);
    wr(1, 32'h0000_0040);
    wr(0, 32'h7);
    for (int i = 0; i < 20; i++) rd(0);
    wr(0, 32'h0);
    wr(1, 32'h0000_0001);
    wr(0, 32'hC);
    press(1);
    idle(5);
    check("step_rotr", 32'(leds), 32'h80);
    press(0);
    idle(5);
    rd(0);
    check("btn_run", 32'(s0_readdata[0]), 32'h1);
    wr(0, 32'h4);
    press(0);
    press(1);
    idle(6);
    rd(0);
    check("btn_disabled", 32'(s0_readdata[0]), 32'h0);
    wr(1, 32'h0000_0501);
    wr(0, 32'hB);
    button_n[0] = 1'b0;
    idle(2);
    wr(0, 32'hA);
    button_n[0] = 1'b1;
    rd(0);
    check("wr_beats_btn", 32'(s0_readdata[0]), 32'h0);
    idle(4);
    wr(0, 32'h3);
    wr(1, 32'h0000_0311);
    idle(3);
    wr(1, 32'h0000_035A);
    cycle();
    check("wr_beats_tick", 32'(leds), 32'h5A);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 9);
      s0_write = ($urandom_range(0, 5) == 0);
      s0_address = 1'($urandom_range(0, 1));
      s0_read = 1'($urandom_range(0, 1));
      s0_writedata = s0_address ? {24'($urandom_range(0, 6)), (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom)}
                                : {28'h0, 4'($urandom)};
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) button_n[b] = ~button_n[b];
      cycle();
    end
    s0_write = 0; s0_read = 0; button_n = 4'hF;
    idle(5);
    wr(1, 32'h0000_0281);
    wr(0, 32'h3);
    idle($urandom_range(3, 10));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_leds", 32'(leds), 32'h01);
    check("async_reset_rdata", s0_readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd(1);
    check("rd_pat_after_reset", s0_readdata, {DP, 8'h01});
    wr(0, 32'h3);
    idle(int'(DP));
    check("no_early_tick", 32'(leds), 32'h01);
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
